// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Frame/debounced vectors hold one bit per key at index col*4+row.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned NUM_KEYS = NUM_ROWS * NUM_COLS;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    MULTI
  } kp_state_e;

  // Printed legend of the key at (row, col).
  function automatic logic [3:0] key_legend(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'h0;
      4'hD: code = 4'hF;
      4'hE: code = 4'hE;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  function automatic logic [4:0] key_count(input logic [NUM_KEYS-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

  // Index of the lowest set bit; meaningful only when v is one-hot.
  function automatic logic [3:0] first_key(input logic [NUM_KEYS-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int unsigned i = NUM_KEYS; i > 0; i--) begin
      if (v[i-1]) idx = 4'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_frame_debounce.sv
// Whole-frame debouncer: commits a frame to deb once DEBOUNCE_SCANS identical
// frames have been seen in a row, pulsing deb_upd on every commit.
module keypad_frame_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_vld,
  input  logic [NUM_KEYS-1:0] frame,
  output logic [NUM_KEYS-1:0] deb,
  output logic                deb_upd
);

  localparam int unsigned CNT_W = (DEBOUNCE_SCANS < 2) ? 1 : $clog2(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS - 1);

  logic [NUM_KEYS-1:0] prev_frame;
  logic [CNT_W-1:0]    stable_cnt;
  logic [CNT_W-1:0]    cnt_next;
  logic                same;

  assign same = (frame == prev_frame);

  // stable_cnt counts repeats beyond the first occurrence and saturates at CNT_MAX.
  always_comb begin
    cnt_next = '0;
    if (same) begin
      cnt_next = (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_frame <= '0;
      stable_cnt <= '0;
      deb        <= '0;
      deb_upd    <= 1'b0;
    end else begin
      deb_upd <= 1'b0;
      if (frame_vld) begin
        stable_cnt <= cnt_next;
        if (!same) prev_frame <= frame;
        if (cnt_next == CNT_MAX) begin
          deb     <= frame;
          deb_upd <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner: column drive, row synchroniser, frame capture and the
// key-acceptance FSM around the frame debouncer.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned DIV_W          = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row_n,
  output logic [NUM_COLS-1:0] col_n,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_held,
  output logic                multi_key
);

  localparam logic [DIV_W-1:0] SLOT_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0]    slot_cnt;
  logic [1:0]          col;
  logic [1:0]          col_next;
  logic [NUM_ROWS-1:0] row_meta;
  logic [NUM_ROWS-1:0] row_sync;
  logic [11:0]         frame_lo;
  logic [NUM_KEYS-1:0] frame_full;
  logic                slot_end;
  logic                frame_vld;
  logic [NUM_KEYS-1:0] deb;
  logic                deb_upd;
  logic [3:0]          key_idx;
  kp_state_e           state;

  assign slot_end   = (slot_cnt == SLOT_LAST);
  assign frame_vld  = slot_end && (col == 2'd3);
  assign col_next   = col + 2'd1;
  // Column 3 is never stored: it goes straight from the synchroniser into the frame.
  assign frame_full = {~row_sync, frame_lo};
  assign key_idx    = first_key(deb);

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt <= '0;
      col      <= '0;
      col_n    <= 4'b0111;
      row_meta <= '1;
      row_sync <= '1;
      frame_lo <= '0;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
      if (slot_end) begin
        slot_cnt <= '0;
        col      <= col_next;
        col_n    <= ~(4'b1000 >> col_next);
        case (col)
          2'd0:    frame_lo[3:0]  <= ~row_sync;
          2'd1:    frame_lo[7:4]  <= ~row_sync;
          2'd2:    frame_lo[11:8] <= ~row_sync;
          default: ;
        endcase
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

  keypad_frame_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .frame_vld(frame_vld),
    .frame    (frame_full),
    .deb      (deb),
    .deb_upd  (deb_upd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      multi_key <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (deb_upd) begin
        case (state)
          IDLE: begin
            if (key_count(deb) == 5'd1) begin
              state     <= HELD;
              key_code  <= key_legend(key_idx[1:0], key_idx[3:2]);
              key_valid <= 1'b1;
              key_held  <= 1'b1;
            end else if (deb != '0) begin
              state     <= MULTI;
              multi_key <= 1'b1;
            end
          end
          HELD: begin
            if (deb == '0) begin
              state    <= IDLE;
              key_held <= 1'b0;
            end
          end
          MULTI: begin
            if (deb == '0) begin
              state     <= IDLE;
              multi_key <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: keypad model drives row_n from col_n, a
// frame-level reference predicts outputs on every cycle.
module tb_keypad_matrix_scanner;

  localparam int SCAN_DIV = 8;
  localparam int DEB      = 2;
  localparam int FRAME    = 4 * SCAN_DIV;
  localparam int SETTLE   = (DEB + 1) * FRAME + 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       multi_key;
  logic [15:0] keys = '0;  // pressed keys, index row*4+col

  keypad_matrix_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEB),
    .DIV_W         (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .row_n    (row_n),
    .col_n    (col_n),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held),
    .multi_key(multi_key)
  );

  always #5 clk = ~clk;

  // Column c is driven by col_n[3-c]; a pressed key pulls its row low.
  always_comb begin
    row_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[3-c]) row_n[r] = 1'b0;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0]  legend [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};
  int          edge_no;
  logic [15:0] build;
  logic [15:0] hist[$];
  logic        pending;
  logic [15:0] pend_deb;
  int          st;           // 0 none accepted, 1 key accepted, 2 several keys
  logic [3:0]  e_code;
  logic        e_valid, e_held, e_multi;
  int          model_pulses = 0;
  int          dut_pulses   = 0;

  task automatic model_reset();
    edge_no = 0;
    build   = '0;
    hist.delete();
    hist.push_back(16'h0);
    pending = 1'b0;
    st      = 0;
    e_code  = '0;
    e_valid = 1'b0;
    e_held  = 1'b0;
    e_multi = 1'b0;
  endtask

  // Keys present after edge 8c+5 are what column c contributes to the frame.
  task automatic sample_keys();
    int  c;
    logic all_eq;
    if (edge_no % SCAN_DIV == SCAN_DIV - 3) begin
      c = (edge_no / SCAN_DIV) % 4;
      for (int r = 0; r < 4; r++) build[r*4+c] = keys[r*4+c];
      if (c == 3) begin
        hist.push_back(build);
        if (hist.size() > DEB) void'(hist.pop_front());
        all_eq = (hist.size() == DEB);
        foreach (hist[i]) if (hist[i] != build) all_eq = 1'b0;
        if (all_eq) begin
          pending  = 1'b1;
          pend_deb = build;
        end
      end
    end
  endtask

  task automatic apply_fsm();
    int k;
    e_valid = 1'b0;
    if (pending && (edge_no % FRAME == 1)) begin
      pending = 1'b0;
      if (st == 0) begin
        if ($countones(pend_deb) == 1) begin
          k = 0;
          for (int i = 0; i < 16; i++) if (pend_deb[i]) k = i;
          st = 1; e_code = legend[k]; e_valid = 1'b1; e_held = 1'b1;
          model_pulses++;
        end else if (pend_deb != 0) begin
          st = 2; e_multi = 1'b1;
        end
      end else if (pend_deb == 0) begin
        st = 0; e_held = 1'b0; e_multi = 1'b0;
      end
    end
  endtask

  task automatic tick();
    logic [3:0] e_col;
    sample_keys();
    @(posedge clk);
    #1;
    edge_no++;
    apply_fsm();
    e_col = 4'b1000 >> ((edge_no / SCAN_DIV) % 4);
    e_col = ~e_col;
    check("outputs", {key_valid, key_held, multi_key, key_code}, {e_valid, e_held, e_multi, e_code});
    check("col_n", col_n, e_col);
    if (key_valid) dut_pulses++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    model_reset();
    check("reset_outputs", {key_valid, key_held, multi_key, key_code}, 7'd0);
    check("reset_col_n", col_n, 4'b0111);
  endtask

  int p, mp, k, k2;

  initial begin
    // 1: reset and column sequence
    keys = '0;
    do_reset(3);
    run(2 * FRAME);

    // 2: single stable key r1c2 -> 6
    run($urandom_range(0, FRAME - 1));
    p = dut_pulses;
    keys[1*4+2] = 1'b1;
    run(SETTLE);
    check("s2_pulse_in_time", dut_pulses - p, 1);
    run(2 * FRAME);
    check("s2_pulses", dut_pulses - p, 1);
    check("s2_code", key_code, 4'h6);
    check("s2_held", key_held, 1);
    keys = '0;
    run(3 * FRAME + 4);
    check("s2_release_held", key_held, 0);
    check("s2_code_kept", key_code, 4'h6);

    // 3: r0c3 bouncing for three frames, then stable -> A
    run($urandom_range(FRAME, 2 * FRAME));
    p = dut_pulses; mp = model_pulses;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (i % 5 == 0) keys[0*4+3] = ~keys[0*4+3];
      tick();
    end
    keys[0*4+3] = 1'b1;
    run(SETTLE + 10);
    check("s3_pulses", dut_pulses - p, 1);
    check("s3_model_pulses", dut_pulses - p, model_pulses - mp);
    check("s3_code", key_code, 4'hA);
    keys = '0;
    run(SETTLE + 10);

    // 4: r0c0 + r3c3 together
    p = dut_pulses;
    keys[0] = 1'b1;
    keys[15] = 1'b1;
    run(SETTLE + 10);
    check("s4_multi", multi_key, 1);
    check("s4_no_pulse", dut_pulses - p, 0);
    keys[15] = 1'b0;
    run(SETTLE + 10);
    check("s4_multi_partial", multi_key, 1);
    check("s4_no_pulse_partial", dut_pulses - p, 0);
    keys = '0;
    run(SETTLE + 10);
    check("s4_multi_clear", multi_key, 0);
    check("s4_held_clear", key_held, 0);

    // 5: r2c1 held, then r3c0 added
    p = dut_pulses;
    keys[2*4+1] = 1'b1;
    run(SETTLE + 10);
    check("s5_pulse", dut_pulses - p, 1);
    check("s5_code", key_code, 4'h8);
    keys[3*4+0] = 1'b1;
    run(SETTLE + 10);
    check("s5_no_new_pulse", dut_pulses - p, 1);
    check("s5_code_kept", key_code, 4'h8);
    check("s5_held_both", key_held, 1);
    keys[2*4+1] = 1'b0;
    run(SETTLE + 10);
    check("s5_held_one_left", key_held, 1);
    keys = '0;
    run(SETTLE + 10);
    check("s5_released", key_held, 0);

    // 6: reset while r3c1 held
    keys[3*4+1] = 1'b1;
    run(SETTLE + 10);
    check("s6_code_before", key_code, 4'hF);
    run($urandom_range(0, FRAME - 1));
    do_reset(1);
    check("s6_held_after_reset", key_held, 0);
    check("s6_code_after_reset", key_code, 4'h0);
    p = dut_pulses;
    run(SETTLE + 10);
    check("s6_repulse", dut_pulses - p, 1);
    check("s6_code", key_code, 4'hF);
    keys = '0;
    run(SETTLE + 10);

    // random presses, occasionally with a second key
    for (int it = 0; it < 6; it++) begin
      p = dut_pulses; mp = model_pulses;
      k = $urandom_range(0, 15);
      keys[k] = 1'b1;
      if ($urandom_range(0, 2) == 0) begin
        k2 = $urandom_range(0, 15);
        run($urandom_range(0, FRAME));
        keys[k2] = 1'b1;
      end
      run($urandom_range(2 * FRAME, 5 * FRAME));
      keys = '0;
      run(SETTLE + 10);
      check("rnd_pulses", dut_pulses - p, model_pulses - mp);
      check("rnd_idle", {key_held, multi_key}, 2'b00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
